// File: rtl/sync_bcd_down_counter.sv
// sync_bcd_down_counter: loadable multi-digit BCD countdown with one-shot or auto-reload terminal behaviour
module sync_bcd_down_counter #(
    parameter int DIGITS = 2,
    parameter bit RELOAD = 1'b0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  load,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   preset,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  busy,
    output logic                  done
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, next_state;
    logic [W-1:0]   reload_q, next_reload, next_count, sat;
    logic           next_tc;

    function automatic logic [W-1:0] sat_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++)
            r[4*i +: 4] = v[4*i +: 4] > 4'd9 ? 4'd9 : v[4*i +: 4];
        return r;
    endfunction

    // Borrow ripples through every trailing zero digit, turning each into 9.
    function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = b ? (v[4*i +: 4] == 4'd0 ? 4'd9 : v[4*i +: 4] - 4'd1) : v[4*i +: 4];
            b = b && (v[4*i +: 4] == 4'd0);
        end
        return r;
    endfunction

    always_comb begin
        sat         = sat_bcd(preset);
        next_state  = state;
        next_count  = count;
        next_reload = reload_q;
        next_tc     = 1'b0;
        if (load) begin
            next_count  = sat;
            next_reload = sat;
            next_state  = sat != '0 ? RUN : DONE;
        end else if (state == RUN && enable) begin
            next_tc    = count == W'(1);
            next_count = count != W'(1) ? dec_bcd(count) : (RELOAD ? reload_q : '0);
            next_state = count == W'(1) && !RELOAD ? DONE : RUN;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            count    <= '0;
            reload_q <= '0;
            tc       <= 1'b0;
        end else begin
            state    <= next_state;
            count    <= next_count;
            reload_q <= next_reload;
            tc       <= next_tc;
        end
    end

    assign busy = state == RUN;
    assign done = state == DONE;
endmodule
